// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard and control-transfer controller for the 5-stage forwarding
// core. Produces the stall/flush controls for the PC register and the IF/ID,
// ID/EX, EX/MEM and MEM/WB stage registers, supervises data-memory wait with a
// timeout FSM, and keeps saturating performance counters.
//
// Ports:
//   i_clk            clock, rising edge
//   i_reset          asynchronous, active-low reset
//   i_id_inst        instruction in ID (rs1=[19:15], rs2=[24:20])
//   i_id_use_rs1/2   ID instruction reads rs1 / rs2
//   i_ex_rd          destination register of the EX instruction
//   i_ex_regwen      EX instruction writes the register file
//   i_ex_wb_sel      EX instruction write-back select
//   i_ex_redirect    EX resolved a taken branch/jump
//   i_mem_wait       data memory not ready for the MEM-stage instruction
//   i_err_clr        synchronous clear of ERROR
//   i_cnt_clr        synchronous clear of all performance counters
//   o_pc_stall       hold PC
//   o_stall_12/23/34 hold IF/ID, ID/EX, EX/MEM
//   o_flush_12/23    zero IF/ID, ID/EX
//   o_flush_45       zero MEM/WB (bubble)
//   o_pc_redirect    PC mux selects the EX target
//   o_state          0=RUN, 1=MEM_WAIT, 3=ERROR
//   o_timeout        high while in ERROR
//   o_stall_cnt      stall cycles
//   o_loaduse_cnt    load-use bubbles
//   o_redirect_cnt   redirects
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int         CNT_W      = 32,
  parameter int         TIMEOUT    = 255,
  parameter logic [1:0] WB_SEL_MEM = 2'b01
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_id_inst,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_regwen,
  input  logic [1:0]       i_ex_wb_sel,
  input  logic             i_ex_redirect,
  input  logic             i_mem_wait,
  input  logic             i_err_clr,
  input  logic             i_cnt_clr,
  output logic             o_pc_stall,
  output logic             o_stall_12,
  output logic             o_flush_12,
  output logic             o_stall_23,
  output logic             o_flush_23,
  output logic             o_stall_34,
  output logic             o_flush_45,
  output logic             o_pc_redirect,
  output logic [1:0]       o_state,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_loaduse_cnt,
  output logic [CNT_W-1:0] o_redirect_cnt
);

  // Wait counter is wide enough to hold TIMEOUT itself; the increment carries
  // one extra bit so the compare against TIMEOUT never wraps.
  localparam int              WCNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W:0] TIMEOUT_V = (WCNT_W + 1)'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd3
  } state_t;

  state_t            state_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [WCNT_W:0]   wcnt_inc;
  logic              timeout_q;

  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       loaduse;
  logic       loaduse_issue;
  logic       count_en;

  // Opcode, funct and rd fields of the ID instruction are not needed here.
  logic unused_inst;
  assign unused_inst = ^{i_id_inst[31:25], i_id_inst[14:0]};

  assign id_rs1 = i_id_inst[19:15];
  assign id_rs2 = i_id_inst[24:20];

  // A load in EX whose result is needed by ID cannot be forwarded in time.
  // x0 is never a real dependency.
  assign loaduse = i_ex_regwen
                && (i_ex_wb_sel == WB_SEL_MEM)
                && (i_ex_rd != 5'd0)
                && ((i_id_use_rs1 && (id_rs1 == i_ex_rd))
                 || (i_id_use_rs2 && (id_rs2 == i_ex_rd)));

  // ---------------------------------------------------------------------------
  // Stall / flush / redirect decode.
  // Priority: ERROR > memory wait > EX redirect > load-use.
  // A redirect seen during memory wait is simply not acted on: the branch is
  // held in ID/EX, so the redirect is still asserted on the first cycle after
  // the wait drops and issues then.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_pc_stall    = 1'b0;
    o_stall_12    = 1'b0;
    o_flush_12    = 1'b0;
    o_stall_23    = 1'b0;
    o_flush_23    = 1'b0;
    o_stall_34    = 1'b0;
    o_flush_45    = 1'b0;
    o_pc_redirect = 1'b0;
    loaduse_issue = 1'b0;

    if (state_q == ST_ERROR) begin
      // Freeze the whole pipeline until software clears the error.
      o_pc_stall = 1'b1;
      o_stall_12 = 1'b1;
      o_stall_23 = 1'b1;
      o_stall_34 = 1'b1;
    end else if (i_mem_wait) begin
      // Hold everything up to EX/MEM and bubble into WB while MEM waits.
      o_pc_stall = 1'b1;
      o_stall_12 = 1'b1;
      o_stall_23 = 1'b1;
      o_stall_34 = 1'b1;
      o_flush_45 = 1'b1;
    end else if (i_ex_redirect) begin
      // IF and ID hold wrong-path instructions; any load-use on them is moot.
      o_pc_redirect = 1'b1;
      o_flush_12    = 1'b1;
      o_flush_23    = 1'b1;
    end else if (loaduse) begin
      // Hold PC and IF/ID, inject one bubble into ID/EX.
      o_pc_stall    = 1'b1;
      o_stall_12    = 1'b1;
      o_flush_23    = 1'b1;
      loaduse_issue = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory-wait supervision FSM.
  // ---------------------------------------------------------------------------
  assign wcnt_inc = {1'b0, wcnt_q} + {{WCNT_W{1'b0}}, 1'b1};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_RUN;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      case (state_q)
        ST_ERROR: begin
          // Sticky until cleared; memory wait no longer matters here.
          if (i_err_clr) begin
            state_q   <= ST_RUN;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
          end
        end
        default: begin
          if (i_mem_wait) begin
            if (wcnt_inc == TIMEOUT_V) begin
              // This edge ends the TIMEOUT-th consecutive wait cycle.
              state_q   <= ST_ERROR;
              wcnt_q    <= '0;
              timeout_q <= 1'b1;
            end else begin
              state_q <= ST_MEM_WAIT;
              wcnt_q  <= wcnt_inc[WCNT_W-1:0];
            end
          end else begin
            state_q <= ST_RUN;
            wcnt_q  <= '0;
          end
        end
      endcase
    end
  end

  assign o_state   = state_q;
  assign o_timeout = timeout_q;

  // ---------------------------------------------------------------------------
  // Saturating performance counters; frozen while in ERROR, clear has
  // priority over increment.
  // ---------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign count_en = (state_q != ST_ERROR);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_stall_cnt    <= '0;
      o_loaduse_cnt  <= '0;
      o_redirect_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_stall_cnt    <= '0;
      o_loaduse_cnt  <= '0;
      o_redirect_cnt <= '0;
    end else if (count_en) begin
      if (o_pc_stall)    o_stall_cnt    <= sat_inc(o_stall_cnt);
      if (loaduse_issue) o_loaduse_cnt  <= sat_inc(o_loaduse_cnt);
      if (o_pc_redirect) o_redirect_cnt <= sat_inc(o_redirect_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. Directed scenarios followed by
// randomized stimulus, all compared every cycle against a behavioural model
// that tracks a run length of memory wait, an error flag and three integer
// counters.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int CNT_W    = 8;
  localparam int TIMEOUT  = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic [31:0]      i_id_inst;
  logic             i_id_use_rs1;
  logic             i_id_use_rs2;
  logic [4:0]       i_ex_rd;
  logic             i_ex_regwen;
  logic [1:0]       i_ex_wb_sel;
  logic             i_ex_redirect;
  logic             i_mem_wait;
  logic             i_err_clr;
  logic             i_cnt_clr;
  logic             o_pc_stall;
  logic             o_stall_12;
  logic             o_flush_12;
  logic             o_stall_23;
  logic             o_flush_23;
  logic             o_stall_34;
  logic             o_flush_45;
  logic             o_pc_redirect;
  logic [1:0]       o_state;
  logic             o_timeout;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_loaduse_cnt;
  logic [CNT_W-1:0] o_redirect_cnt;

  hazard_ctrl #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .WB_SEL_MEM (2'b01)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_id_inst      (i_id_inst),
    .i_id_use_rs1   (i_id_use_rs1),
    .i_id_use_rs2   (i_id_use_rs2),
    .i_ex_rd        (i_ex_rd),
    .i_ex_regwen    (i_ex_regwen),
    .i_ex_wb_sel    (i_ex_wb_sel),
    .i_ex_redirect  (i_ex_redirect),
    .i_mem_wait     (i_mem_wait),
    .i_err_clr      (i_err_clr),
    .i_cnt_clr      (i_cnt_clr),
    .o_pc_stall     (o_pc_stall),
    .o_stall_12     (o_stall_12),
    .o_flush_12     (o_flush_12),
    .o_stall_23     (o_stall_23),
    .o_flush_23     (o_flush_23),
    .o_stall_34     (o_stall_34),
    .o_flush_45     (o_flush_45),
    .o_pc_redirect  (o_pc_redirect),
    .o_state        (o_state),
    .o_timeout      (o_timeout),
    .o_stall_cnt    (o_stall_cnt),
    .o_loaduse_cnt  (o_loaduse_cnt),
    .o_redirect_cnt (o_redirect_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_state;     // 0 RUN, 1 MEM_WAIT, 3 ERROR
  int m_wait;      // consecutive wait cycles seen so far
  int m_cnt[3];    // stall, load-use, redirect

  // Control vector order: pc_stall, stall_12, flush_12, stall_23, flush_23,
  // stall_34, flush_45, pc_redirect.
  localparam logic [7:0] CTL_NONE  = 8'b0000_0000;
  localparam logic [7:0] CTL_WAIT  = 8'b1101_0110;
  localparam logic [7:0] CTL_ERR   = 8'b1101_0100;
  localparam logic [7:0] CTL_REDIR = 8'b0010_1001;
  localparam logic [7:0] CTL_LU    = 8'b1100_1000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_ctl();
    return {o_pc_stall, o_stall_12, o_flush_12, o_stall_23, o_flush_23,
            o_stall_34, o_flush_45, o_pc_redirect};
  endfunction

  function automatic logic [31:0] mk_inst(input int rs1, input int rs2);
    logic [4:0] a;
    logic [4:0] b;
    a = rs1[4:0];
    b = rs2[4:0];
    return {7'b0, b, a, 3'b000, 5'd6, 7'h33};
  endfunction

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Returns {bubble_issued, control vector} for the current inputs.
  function automatic logic [8:0] exp_ctl();
    bit dep;
    dep = i_ex_regwen && (i_ex_wb_sel == 2'b01) && (i_ex_rd != 0) &&
          ((i_id_use_rs1 && (i_id_inst[19:15] == i_ex_rd)) ||
           (i_id_use_rs2 && (i_id_inst[24:20] == i_ex_rd)));
    if (m_state == 3)       return {1'b0, CTL_ERR};
    else if (i_mem_wait)    return {1'b0, CTL_WAIT};
    else if (i_ex_redirect) return {1'b0, CTL_REDIR};
    else if (dep)           return {1'b1, CTL_LU};
    else                    return {1'b0, CTL_NONE};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_wait  = 0;
    m_cnt   = '{0, 0, 0};
  endtask

  task automatic check_all();
    logic [8:0] e;
    e = exp_ctl();
    check("ctl",          dut_ctl(),      e[7:0]);
    check("state",        o_state,        m_state);
    check("timeout",      o_timeout,      m_state == 3);
    check("stall_cnt",    o_stall_cnt,    m_cnt[0]);
    check("loaduse_cnt",  o_loaduse_cnt,  m_cnt[1]);
    check("redirect_cnt", o_redirect_cnt, m_cnt[2]);
  endtask

  task automatic model_step();
    logic [8:0] e;
    e = exp_ctl();
    if (i_cnt_clr) begin
      m_cnt = '{0, 0, 0};
    end else if (m_state != 3) begin
      if (e[7]) m_cnt[0] = sat(m_cnt[0]);
      if (e[8]) m_cnt[1] = sat(m_cnt[1]);
      if (e[0]) m_cnt[2] = sat(m_cnt[2]);
    end
    if (m_state == 3) begin
      if (i_err_clr) begin
        m_state = 0;
        m_wait  = 0;
      end
    end else if (i_mem_wait) begin
      m_wait++;
      if (m_wait == TIMEOUT) begin
        m_state = 3;
        m_wait  = 0;
      end else begin
        m_state = 1;
      end
    end else begin
      m_state = 0;
      m_wait  = 0;
    end
  endtask

  // Called just after a falling edge with inputs already driven: compare,
  // advance the model across the rising edge, return at the next falling edge.
  task automatic tick();
    #1;
    check_all();
    model_step();
    @(negedge i_clk);
  endtask

  task automatic set_in(input logic [31:0] inst, input bit u1, input bit u2,
                        input int rd, input bit wen, input logic [1:0] wb,
                        input bit redir, input bit mwait);
    i_id_inst     = inst;
    i_id_use_rs1  = u1;
    i_id_use_rs2  = u2;
    i_ex_rd       = rd[4:0];
    i_ex_regwen   = wen;
    i_ex_wb_sel   = wb;
    i_ex_redirect = redir;
    i_mem_wait    = mwait;
    i_err_clr     = 1'b0;
    i_cnt_clr     = 1'b0;
  endtask

  task automatic idle();
    set_in(32'h0, 1'b0, 1'b0, 0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  // Asserts reset between clock edges, so any visible effect is asynchronous.
  task automatic pulse_reset();
    i_reset = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_state", o_state, 2'd0);
    check("rst_cnt",   o_stall_cnt | o_loaduse_cnt | o_redirect_cnt, 0);
    @(negedge i_clk);
    i_reset = 1'b1;
  endtask

  initial begin
    logic [31:0] add_x6_x5_x7;
    int burst;
    add_x6_x5_x7 = mk_inst(5, 7);

    i_reset = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge i_clk);
    #1;
    check("reset_state",   o_state, 2'd0);
    check("reset_timeout", o_timeout, 1'b0);
    check("reset_ctl",     dut_ctl(), CTL_NONE);
    @(negedge i_clk);
    i_reset = 1'b1;

    // Load-use: lw x5 in EX, add x6,x5,x7 in ID.
    set_in(add_x6_x5_x7, 1'b1, 1'b0, 5, 1'b1, 2'b01, 1'b0, 1'b0);
    #1;
    check("lu_ctl", dut_ctl(), CTL_LU);
    tick();
    set_in(add_x6_x5_x7, 1'b1, 1'b0, 0, 1'b0, 2'b00, 1'b0, 1'b0);
    #1;
    check("lu_bubble_ctl", dut_ctl(), CTL_NONE);
    check("lu_cnt_1",      o_loaduse_cnt, 1);
    check("lu_stall_cnt_1", o_stall_cnt, 1);
    tick();

    // No false stalls.
    set_in(mk_inst(0, 3), 1'b1, 1'b1, 0, 1'b1, 2'b01, 1'b0, 1'b0);
    #1;
    check("nofs_rd0", o_pc_stall, 1'b0);
    tick();
    set_in(mk_inst(5, 7), 1'b1, 1'b0, 7, 1'b1, 2'b01, 1'b0, 1'b0);
    #1;
    check("nofs_rs2_unused", o_pc_stall, 1'b0);
    tick();
    set_in(add_x6_x5_x7, 1'b1, 1'b0, 5, 1'b1, 2'b00, 1'b0, 1'b0);
    #1;
    check("nofs_wbsel_alu", o_pc_stall, 1'b0);
    tick();

    // Redirect beats load-use.
    set_in(add_x6_x5_x7, 1'b1, 1'b0, 5, 1'b1, 2'b01, 1'b1, 1'b0);
    #1;
    check("redir_lu_ctl", dut_ctl(), CTL_REDIR);
    tick();
    idle();
    #1;
    check("redir_cnt_1",     o_redirect_cnt, 1);
    check("redir_lu_cnt_eq", o_loaduse_cnt, 1);
    i_cnt_clr = 1'b1;
    tick();

    // Three wait cycles with a redirect pending, then the deferred redirect.
    for (int k = 0; k < 3; k++) begin
      set_in(32'h0, 1'b0, 1'b0, 0, 1'b0, 2'b00, 1'b1, 1'b1);
      #1;
      check("wait_ctl", dut_ctl(), CTL_WAIT);
      if (k > 0) check("wait_state", o_state, 2'd1);
      tick();
    end
    set_in(32'h0, 1'b0, 1'b0, 0, 1'b0, 2'b00, 1'b1, 1'b0);
    #1;
    check("deferred_redir", dut_ctl(), CTL_REDIR);
    tick();
    idle();
    #1;
    check("post_wait_state", o_state, 2'd0);
    check("wait_stall_cnt",  o_stall_cnt, 3);
    check("wait_redir_cnt",  o_redirect_cnt, 1);
    tick();

    // Timeout into ERROR, stickiness, clear.
    for (int k = 0; k < TIMEOUT; k++) begin
      set_in(32'h0, 1'b0, 1'b0, 0, 1'b0, 2'b00, 1'b0, 1'b1);
      tick();
    end
    #1;
    check("err_state",   o_state, 2'd3);
    check("err_timeout", o_timeout, 1'b1);
    check("err_ctl",     dut_ctl(), CTL_ERR);
    tick();
    idle();
    #1;
    check("err_sticky", o_state, 2'd3);
    tick();
    i_err_clr = 1'b1;
    tick();
    idle();
    #1;
    check("err_clr_state",   o_state, 2'd0);
    check("err_clr_timeout", o_timeout, 1'b0);
    tick();

    // Reset mid MEM_WAIT, then a full fresh count is needed for ERROR.
    for (int k = 0; k < 2; k++) begin
      set_in(32'h0, 1'b0, 1'b0, 0, 1'b0, 2'b00, 1'b1, 1'b1);
      tick();
    end
    pulse_reset();
    for (int k = 0; k < TIMEOUT - 1; k++) tick();
    #1;
    check("fresh_count_not_err", o_state, 2'd1);
    tick();
    #1;
    check("fresh_count_err", o_state, 2'd3);
    idle();
    i_err_clr = 1'b1;
    tick();

    // Saturation, then clear winning over increment.
    set_in(add_x6_x5_x7, 1'b1, 1'b0, 5, 1'b1, 2'b01, 1'b0, 1'b0);
    repeat (CNT_MAX + 40) tick();
    #1;
    check("sat_stall_cnt",   o_stall_cnt, CNT_MAX);
    check("sat_loaduse_cnt", o_loaduse_cnt, CNT_MAX);
    i_cnt_clr = 1'b1;
    tick();
    idle();
    #1;
    check("clr_over_inc", o_loaduse_cnt, 0);
    tick();

    // Randomized stimulus against the model.
    burst = 0;
    for (int n = 0; n < 3000; n++) begin
      set_in(mk_inst($urandom_range(0, 3), $urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0), 1'b0);
      if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 6);
      if (burst > 0) begin
        i_mem_wait = 1'b1;
        burst--;
      end
      i_err_clr = 1'($urandom_range(0, 5) == 0);
      i_cnt_clr = 1'($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
